// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic int div_of(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Any nibble outside 0..9 is clamped to 9 so the counter never holds a non-BCD digit.
    function automatic logic [3:0] sat_bcd(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit: applies an incoming carry/borrow and reports its own.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       step_in,
    output logic [3:0] next_digit,
    output logic       step_out
);

    always_comb begin
        next_digit = digit;
        step_out   = 1'b0;
        if (step_in) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    next_digit = BCD_MIN;
                    step_out   = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_MIN) begin
                    next_digit = BCD_MAX;
                    step_out   = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Parametrised multi-digit BCD up/down counter stepped by an internal prescaler.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tick,
    output logic                wrap
);

    localparam int DIV = div_of(CLK_HZ, TICK_HZ);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]       presc;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] next_count;
    logic [4*DIGITS-1:0] load_sat;
    logic                step;

    // Digit 0 always receives the step; the ripple decides which upper digits move.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit     (count[4*i +: 4]),
            .up        (up),
            .step_in   (carry[i]),
            .next_digit(next_count[4*i +: 4]),
            .step_out  (carry[i+1])
        );
        assign load_sat[4*i +: 4] = sat_bcd(load_val[4*i +: 4]);
    end

    assign step = tick & en & ~clear & ~load;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            presc <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= en && (presc == PRESC_LAST);
            wrap <= 1'b0;
            if (clear) begin
                count <= '0;
                presc <= '0;
            end else if (load) begin
                count <= load_sat;
                presc <= '0;
            end else begin
                if (en) begin
                    presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
                end
                if (step) begin
                    count <= next_count;
                    wrap  <= carry[DIGITS];
                end
            end
        end
    end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Parametrised multi-digit BCD counter driven by an internal prescaler; successor to the single-digit seconds counter.
- Adds digit count, tick rate, up/down direction, enable, synchronous clear, parallel load and wrap/carry flag.
- Feeds 7-segment display drivers and game timers; `tick` is exported so other blocks can share the time base.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count-step rate in Hz. DIV = CLK_HZ/TICK_HZ, integer, must be >= 1.
- DIGITS, 4, number of BCD digits. Range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  1 = prescaler runs and counter steps; 0 = everything holds.
- up  input  1  1 = count up, 0 = count down. Sampled at the step cycle.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  load value, digit 0 in [3:0].
- count  output  4*DIGITS  current BCD value, digit 0 (ones) in [3:0].
- tick  output  1  one-cycle pulse when the prescaler expires.
- wrap  output  1  one-cycle pulse on the step that wraps.
  - Up: all 9s -> all 0s.
  - Down: all 0s -> all 9s.

Behaviour:
- Reset (reset=1 at a posedge): count=0, prescaler=0, tick=0, wrap=0. Reset overrides all other inputs.
- Prescaler:
  - Width is $clog2(DIV), minimum 1 bit.
  - When en=1 it increments each cycle. When it equals DIV-1 it returns to 0.
  - tick is registered. It is 1 in the cycle after the prescaler was at DIV-1 with en=1, and 0 otherwise.
  - When en=0 the prescaler holds its value.
  - If DIV=1, tick=1 on every cycle following a cycle with en=1.
- Step:
  - Occurs in the cycle where tick=1 and en=1, with no clear and no load.
  - Count changes on the clock edge that ends the tick cycle. Latency from prescaler expiry to count change is 2 edges.
- Priority, highest first: reset > clear > load > step > hold.
  - clear: count=0, prescaler=0, wrap=0.
  - load: count=load_val, prescaler=0, wrap=0.
  - A step that coincides with clear or load is dropped.
- Load sanitising: any load_val digit > 9 is stored as 9. The other digits load unchanged.
- Up step:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit. The carry ripples combinationally within one cycle.
  - A carry out of the top digit sets wrap=1 for the next cycle only.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - A borrow out of the top digit sets wrap=1.
- Direction change: up may toggle on any cycle. Only its value in the step cycle matters. No glitch or extra step results.
- Holding: en=0 in the tick cycle suppresses the step. Because tick is registered, that step is lost, not deferred.
- Outputs: count is a register and never holds a non-BCD digit. tick and wrap are registered pulses.

Decomposition:
- Shared package `bcd_pkg`:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - Function `div_of(clk_hz, tick_hz)`.
  - Function `sat_bcd(nibble)`, which clamps a nibble to 9.
- Sub-module `bcd_digit`:
  - Combinational.
  - Inputs: digit, up, step_in (carry/borrow in).
  - Outputs: next_digit, step_out.
- The top level instantiates DIGITS copies of `bcd_digit` in a generate chain and keeps the prescaler and registers locally.

Test Plan (CLK_HZ=10, TICK_HZ=1 -> DIV=10, DIGITS=2 unless noted):
- Reset, en=1, up=1 for 100 cycles:
  - tick pulses every 10 cycles.
  - count goes 00,01,...,10 after 10 ticks.
  - wrap stays 0.
- Up wrap: load 8'h99, en=1, up=1, wait one tick:
  - count=8'h00.
  - wrap=1 for exactly one cycle.
- Down wrap: load 8'h00, up=0, one tick:
  - count=8'h99, wrap pulse.
  - Then load 8'h10 and run one tick: count=8'h09, no wrap.
- Load sanitising and priority:
  - Load 8'hAF: count=8'h99.
  - Assert clear and load 8'h42 together with a tick: count=8'h00.
  - Assert load and tick together: count=8'h42, the step is dropped, the prescaler restarts at 0.
- Enable gating: count=8'h05; drop en for 25 cycles, including over the would-be tick.
  - count stays 05 and the prescaler holds.
  - After en returns, the next tick arrives after the remaining prescaler cycles.
- Reset mid-count: assert reset with count=8'h37 and prescaler mid-way.
  - Next cycle count=0, tick=0, wrap=0.
  - The first tick arrives 10 enabled cycles after release.
  - DIV=1 variant (CLK_HZ=TICK_HZ=1): count steps every enabled cycle.
